// File: rtl/alu_nibble_sequencer_pkg.sv
// rtl/alu_nibble_sequencer_pkg.sv - shared op codes, state encoding and helpers for the nibble sequencer
package alu_nibble_sequencer_pkg;

  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 000 and 001 have no ALU meaning; every other code does.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op[2] | op[1];
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_alu.sv
// rtl/alu_nibble_sequencer_alu.sv - 4-bit combinational ALU slice with carry in/out
module alu_nibble_sequencer_alu
  import alu_nibble_sequencer_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] out,
  output logic       cout
);

  logic [4:0] sum;

  // Arithmetic ops produce a carry; logic ops report carry 0; unknown codes yield X.
  always_comb begin
    sum  = 5'd0;
    out  = 4'bxxxx;
    cout = 1'bx;
    case (sel)
      OP_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b} + {4'd0, cin};
        out  = sum[3:0];
        cout = sum[4];
      end
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        out  = sum[3:0];
        cout = sum[4];
      end
      OP_AND: begin
        out  = a & b;
        cout = 1'b0;
      end
      OP_OR: begin
        out  = a | b;
        cout = 1'b0;
      end
      OP_XOR: begin
        out  = a ^ b;
        cout = 1'b0;
      end
      OP_PASS: begin
        sum  = {1'b0, a} + {4'd0, cin};
        out  = sum[3:0];
        cout = sum[4];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - time-multiplexes one 4-bit ALU over a multi-nibble operand pair
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 2,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             err_q;
  logic             ready_q;
  logic             valid_q;

  logic [2:0]       alu_sel;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic             alu_cin;
  logic [3:0]       alu_out;
  logic             alu_cout;

  // Feed the ALU only while running; otherwise park it on a defined PASS of zero.
  always_comb begin
    alu_sel = OP_PASS;
    alu_a   = 4'd0;
    alu_b   = 4'd0;
    alu_cin = 1'b0;
    if (state == ST_RUN) begin
      alu_sel = op_q;
      alu_a   = a_q[{cnt, 2'b00} +: 4];
      alu_b   = b_q[{cnt, 2'b00} +: 4];
      alu_cin = (cnt == '0) ? cin_q : carry_q;
    end
  end

  alu_nibble_sequencer_alu u_alu (
    .sel  (alu_sel),
    .a    (alu_a),
    .b    (alu_b),
    .cin  (alu_cin),
    .out  (alu_out),
    .cout (alu_cout)
  );

  // Sequencer FSM: capture on handshake, one nibble per RUN cycle, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_PASS;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            a_q      <= req_a;
            b_q      <= req_b;
            cin_q    <= req_cin;
            cnt      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ready_q  <= 1'b0;
            if (op_is_legal(req_op)) begin
              err_q <= 1'b0;
              state <= ST_RUN;
            end else begin
              err_q   <= 1'b1;
              valid_q <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          result_q[{cnt, 2'b00} +: 4] <= alu_out;
          carry_q <= alu_cout;
          if (cnt == LAST) begin
            cnt     <= '0;
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = valid_q;
  assign rsp_result = result_q;
  assign rsp_cout   = carry_q;
  assign rsp_err    = err_q;
  assign rsp_zero   = valid_q && (result_q == '0);

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - directed self-checking bench for the nibble sequencer
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 2;
  localparam int WIDTH = 4 * NIBBLES;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_cout;
  logic             rsp_zero;
  logic             rsp_err;

  int passed = 0;
  int total  = 0;
  logic sel_mon_en = 1'b0;
  logic sel_bad    = 1'b0;

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sel_mon_en && (dut.alu_sel == 3'b000 || dut.alu_sel == 3'b001)) sel_bad = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one op and wait for rsp_valid; lat counts edges after the handshake edge.
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic cin, output int lat);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin tick(); w++; end
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 3'b000; req_a = '0; req_b = '0; req_cin = 1'b0;
    tick(); tick();
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rsp_valid); else passed++;
    total++; if (rsp_result !== 8'h00) $display("FAIL reset_result got %h want 00", rsp_result); else passed++;
    total++; if ({rsp_cout, rsp_zero, rsp_err} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {rsp_cout, rsp_zero, rsp_err}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int lat;
    issue(3'b011, 8'h3C, 8'h0F, 1'b0, lat);
    total++; if (lat !== 2) $display("FAIL add_latency got %0d want 2", lat); else passed++;
    total++; if (rsp_result !== 8'h4B) $display("FAIL add_result got %h want 4b", rsp_result); else passed++;
    total++; if ({rsp_cout, rsp_zero, rsp_err} !== 3'b000)
      $display("FAIL add_flags got %b want 000", {rsp_cout, rsp_zero, rsp_err}); else passed++;
    consume();
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL add_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); else passed++;
  endtask

  task automatic test_sub();
    int lat;
    issue(3'b010, 8'h10, 8'h01, 1'b1, lat);
    total++; if (rsp_result !== 8'h0F || rsp_cout !== 1'b1)
      $display("FAIL sub_nobrrow got %h/%b want 0f/1", rsp_result, rsp_cout); else passed++;
    consume();
    issue(3'b010, 8'h01, 8'h02, 1'b1, lat);
    total++; if (rsp_result !== 8'hFF || rsp_cout !== 1'b0 || rsp_zero !== 1'b0)
      $display("FAIL sub_borrow got %h/%b/%b want ff/0/0", rsp_result, rsp_cout, rsp_zero); else passed++;
    consume();
  endtask

  task automatic test_increment_wrap();
    int lat;
    issue(3'b111, 8'hFF, 8'h55, 1'b1, lat);
    total++; if (rsp_result !== 8'h00 || rsp_cout !== 1'b1 || rsp_zero !== 1'b1)
      $display("FAIL inc_wrap got %h/%b/%b want 00/1/1", rsp_result, rsp_cout, rsp_zero); else passed++;
    consume();
  endtask

  task automatic test_illegal();
    int lat;
    sel_mon_en = 1'b1;
    issue(3'b000, 8'h12, 8'h34, 1'b0, lat);
    total++; if (lat !== 0) $display("FAIL illegal_latency got %0d want 0", lat); else passed++;
    total++; if ({rsp_valid, rsp_err, rsp_zero, rsp_cout} !== 4'b1110 || rsp_result !== 8'h00)
      $display("FAIL illegal_rsp got v/e/z/c=%b res=%h want 1110 res=00",
               {rsp_valid, rsp_err, rsp_zero, rsp_cout}, rsp_result); else passed++;
    total++; if (dut.alu_sel !== 3'b111) $display("FAIL illegal_park got %b want 111", dut.alu_sel); else passed++;
    consume();
    issue(3'b001, 8'h77, 8'h11, 1'b1, lat);
    total++; if (rsp_err !== 1'b1 || rsp_result !== 8'h00)
      $display("FAIL illegal001 got err=%b res=%h want 1/00", rsp_err, rsp_result); else passed++;
    consume();
    sel_mon_en = 1'b0;
    total++; if (sel_bad !== 1'b0) $display("FAIL illegal_sel got %b want 0", sel_bad); else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    issue(3'b110, 8'hA5, 8'hFF, 1'b0, lat);
    total++; if (rsp_result !== 8'h5A || rsp_cout !== 1'b0)
      $display("FAIL xor_result got %h/%b want 5a/0", rsp_result, rsp_cout); else passed++;
    req_op = 3'b011; req_a = 8'h01; req_b = 8'h02; req_cin = 1'b0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rsp_valid !== 1'b1 || rsp_result !== 8'h5A || req_ready !== 1'b0)
        $display("FAIL hold_%0d got v=%b res=%h rdy=%b want 1/5a/0", i, rsp_valid, rsp_result, req_ready);
      else passed++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_idle got v=%b rdy=%b want 0/1", rsp_valid, req_ready); else passed++;
    tick();
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) $display("FAIL bp_accept got %b want 0", req_ready); else passed++;
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    total++; if (lat !== 2 || rsp_result !== 8'h03)
      $display("FAIL bp_next got lat=%0d res=%h want 2/03", lat, rsp_result); else passed++;
    consume();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    req_op = 3'b011; req_a = 8'h3C; req_b = 8'h0F; req_cin = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== 8'h00 ||
                 {rsp_cout, rsp_zero, rsp_err} !== 3'b000)
      $display("FAIL midrst got rdy=%b v=%b res=%h flags=%b want 1/0/00/000",
               req_ready, rsp_valid, rsp_result, {rsp_cout, rsp_zero, rsp_err}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", req_ready); else passed++;
    issue(3'b011, 8'h22, 8'h33, 1'b1, lat);
    total++; if (lat !== 2 || rsp_result !== 8'h56 || rsp_cout !== 1'b0)
      $display("FAIL midrst_fresh got lat=%0d res=%h c=%b want 2/56/0", lat, rsp_result, rsp_cout); else passed++;
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_increment_wrap();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
Multi-nibble operation sequencer that time-multiplexes one 4-bit alu over a WIDTH = 4*NIBBLES bit operand pair.
- Processes one nibble per cycle, LSB first.
- Chains carry_out of nibble i into carry_in of nibble i+1.
- Sits between the core control unit and the 4-bit ALU; exposes a valid/ready request and result interface.

Parameters:
NIBBLES, 2, number of 4-bit slices per operation (>=1); operand width WIDTH = 4*NIBBLES.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  requester presents an operation.
req_ready  output  1  sequencer can accept an operation.
req_op  input  3  ALU select code: 010 sub (A+~B+cin), 011 add, 100 and, 101 or, 110 xor, 111 pass A (+cin).
req_a  input  WIDTH  operand A.
req_b  input  WIDTH  operand B.
req_cin  input  1  carry into nibble 0.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer accepts result.
rsp_result  output  WIDTH  result.
rsp_cout  output  1  carry out of the top nibble.
rsp_zero  output  1  1 when rsp_result == 0.
rsp_err  output  1  1 when req_op was illegal (000 or 001).

Behaviour:
- States: IDLE, RUN, DONE. One clock; reset is asynchronous, active-low (rst_n).
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, rsp_cout 0, rsp_zero 0, rsp_err 0, nibble counter 0.
- req_ready = 1 only in IDLE. rsp_valid = 1 only in DONE.
- IDLE, req_valid=1 (handshake at edge k):
  - Capture req_op, req_a, req_b, req_cin into internal registers.
  - Clear the result register and counter.
  - Go to RUN. Inputs are not sampled again until the next IDLE.
- Illegal op (000/001) at handshake:
  - Go directly to DONE with rsp_err=1, rsp_result=0, rsp_cout=0, rsp_zero=1.
  - The alu is never driven with the illegal code.
- RUN, counter i:
  - ALU inputs = nibble i of captured A and B, captured op.
  - carry_in = captured cin for i=0, otherwise the registered carry from nibble i-1.
  - At the edge, write alu out into result nibble i, register carry_out, and increment the counter.
  - After i = NIBBLES-1, go to DONE.
- Latency:
  - Handshake at edge k; nibbles written at edges k+1..k+NIBBLES.
  - rsp_valid high from edge k+NIBBLES onward.
  - Throughput is one op per NIBBLES+2 cycles minimum.
- Carry is chained uniformly for all ops.
  - Op 111 with cin=1 therefore increments A across the full width.
  - Logic ops with cin=0 give rsp_cout=0.
- rsp_zero is computed combinationally from the final result register, valid in DONE.
- DONE:
  - rsp_* are held stable while rsp_ready=0; req_valid is ignored (req_ready=0).
  - rsp_valid=1 and rsp_ready=1 at an edge: go to IDLE and deassert rsp_valid.
  - A new request cannot be accepted in the same cycle.
- Counter wraps to 0 on entry to RUN, never free-runs. NIBBLES=1 gives a single RUN cycle.
- rst_n low in any state aborts immediately to reset values. Partial results are discarded.
- The alu default branch (X outputs) must never propagate: in IDLE/DONE drive alu sel=111, A=0, B=0, cin=0.

Decomposition:
- Shared package holds:
  - 3-bit op code constants: OP_SUB=3'b010, OP_ADD=3'b011, OP_AND=3'b100, OP_OR=3'b101, OP_XOR=3'b110, OP_PASS=3'b111.
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE.
- One sub-module: the existing 4-bit alu, instantiated once. No other hierarchy.

Test Plan:
1. Add, NIBBLES=2: op=011, A=0x3C, B=0x0F, cin=0 -> after 2 RUN cycles rsp_result=0x4B, cout=0, zero=0, err=0; nibble-0 carry propagates.
2. Sub: op=010, A=0x10, B=0x01, cin=1 -> rsp_result=0x0F, cout=1 (no borrow). Then A=0x01, B=0x02 -> 0xFF, cout=0.
3. Increment wrap: op=111, A=0xFF, B=0x55, cin=1 -> rsp_result=0x00, cout=1, zero=1.
4. Illegal op: op=000, A=0x12, B=0x34 -> next cycle rsp_valid=1, err=1, result=0x00, zero=1; alu sel never observed at 000.
5. Backpressure: complete an XOR 0xA5^0xFF (=0x5A).
   - Hold rsp_ready=0 for 3 cycles while req_valid=1 with new data -> outputs stable, req_ready=0, request not taken.
   - Raise rsp_ready -> IDLE, then the new request is accepted.
6. Reset mid-op: assert rst_n=0 after the first RUN cycle of 0x3C+0x0F -> all outputs at reset values immediately. After release, req_ready=1 and a fresh op completes correctly.
